draw_scheduler: RTL and testbench

- Frame-level controller that sequences the self and enemy drawing datapaths through one shared VGA write port.
- On each frame tick it runs erase-self, erase-enemy, position update, draw-self, draw-enemy, in that order.
- It drives the datapath select (0 = self, 1 = enemy), the erase colour override, the VGA plot enable and the movement-update strobe.
- It sits between the frame-rate divider and the self/enemy datapaths plus their output mux.

---
 rtl/draw_scheduler_pkg.sv | 38 +++
 rtl/draw_scheduler_wait_timer.sv | 25 ++
 rtl/draw_scheduler.sv | 104 ++++++++++
 tb/tb_draw_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/draw_scheduler_pkg.sv
// Shared encodings for the frame draw scheduler: state codes, datapath select values
// and the background colour used while erasing.
package draw_scheduler_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ES_START = 4'd1,
    S_ES_WAIT  = 4'd2,
    S_EE_START = 4'd3,
    S_EE_WAIT  = 4'd4,
    S_UPDATE   = 4'd5,
    S_DS_START = 4'd6,
    S_DS_WAIT  = 4'd7,
    S_DE_START = 4'd8,
    S_DE_WAIT  = 4'd9
  } state_t;

  localparam logic       SEL_SELF  = 1'b0;
  localparam logic       SEL_ENEMY = 1'b1;
  localparam logic [2:0] BG_COLOR  = 3'b000;

  function automatic logic is_start(state_t s);
    return (s == S_ES_START) || (s == S_EE_START) || (s == S_DS_START) || (s == S_DE_START);
  endfunction

  function automatic logic is_wait(state_t s);
    return (s == S_ES_WAIT) || (s == S_EE_WAIT) || (s == S_DS_WAIT) || (s == S_DE_WAIT);
  endfunction

  function automatic logic is_enemy(state_t s);
    return (s == S_EE_START) || (s == S_EE_WAIT) || (s == S_DE_START) || (s == S_DE_WAIT);
  endfunction

  function automatic logic is_erase(state_t s);
    return (s == S_ES_START) || (s == S_ES_WAIT) || (s == S_EE_START) || (s == S_EE_WAIT);
  endfunction

endpackage

// File: rtl/draw_scheduler_wait_timer.sv
// Done-watchdog shared by every WAIT state: cleared while in a START state,
// counts while waiting, flags expiry on the last allowed cycle.
module wait_timer #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt;

  assign expired = en && (cnt == LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 cnt <= '0;
    else if (clear)              cnt <= '0;
    else if (en && cnt != LAST)  cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/draw_scheduler.sv
// Per-frame sequencer: erase self, erase enemy, position update, draw self, draw enemy,
// sharing one VGA write port between the two sprite datapaths.
module draw_scheduler import draw_scheduler_pkg::*; #(
  parameter int FRAMES_PER_MOVE = 4,
  parameter int TIMEOUT_CYCLES  = 20000
) (
  input  logic clk,
  input  logic resetn,
  input  logic frame_tick,
  input  logic enemy_active,
  input  logic self_done,
  input  logic enemy_done,
  output logic self_start,
  output logic enemy_start,
  output logic datapath_select,
  output logic erase,
  output logic plot,
  output logic update_en,
  output logic busy,
  output logic overrun,
  output logic timeout_err
);

  localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_MOVE - 1);

  state_t     state, nxt;
  logic       en_l, pending;
  logic [7:0] frame_cnt;
  logic       tmr_clear, tmr_en, expired, done_ok, adv;

  wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (tmr_clear),
    .en      (tmr_en),
    .expired (expired)
  );

  // Only the done belonging to the datapath being waited on counts.
  always_comb begin
    tmr_clear = is_start(state);
    tmr_en    = is_wait(state);
    done_ok   = is_wait(state) && (is_enemy(state) ? enemy_done : self_done);
    adv       = done_ok || expired;
    nxt       = state;
    case (state)
      S_IDLE:     if (frame_tick || pending) nxt = S_ES_START;
      S_ES_START: nxt = S_ES_WAIT;
      S_ES_WAIT:  if (adv) nxt = en_l ? S_EE_START : S_UPDATE;
      S_EE_START: nxt = S_EE_WAIT;
      S_EE_WAIT:  if (adv) nxt = S_UPDATE;
      S_UPDATE:   nxt = S_DS_START;
      S_DS_START: nxt = S_DS_WAIT;
      S_DS_WAIT:  if (adv) nxt = en_l ? S_DE_START : S_IDLE;
      S_DE_START: nxt = S_DE_WAIT;
      S_DE_WAIT:  if (adv) nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      en_l            <= 1'b0;
      pending         <= 1'b0;
      frame_cnt       <= '0;
      self_start      <= 1'b0;
      enemy_start     <= 1'b0;
      datapath_select <= SEL_SELF;
      erase           <= 1'b0;
      plot            <= 1'b0;
      update_en       <= 1'b0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      state           <= nxt;
      self_start      <= (nxt == S_ES_START) || (nxt == S_DS_START);
      enemy_start     <= (nxt == S_EE_START) || (nxt == S_DE_START);
      datapath_select <= is_enemy(nxt) ? SEL_ENEMY : SEL_SELF;
      erase           <= is_erase(nxt);
      plot            <= is_wait(nxt);
      update_en       <= (nxt == S_UPDATE) && (frame_cnt == FRAME_LAST);
      busy            <= (nxt != S_IDLE);

      if (state == S_IDLE) begin
        if (frame_tick || pending) begin
          en_l    <= enemy_active;
          pending <= 1'b0;
        end
      end else if (frame_tick) begin
        pending <= 1'b1;
        overrun <= 1'b1;
      end

      if (expired && !done_ok) timeout_err <= 1'b1;

      if (state == S_UPDATE)
        frame_cnt <= (frame_cnt == FRAME_LAST) ? 8'd0 : frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: a cycle table for the basic sequence plus
// hand-written multi-frame scenarios with an automatic done responder.
module tb_draw_scheduler;

  localparam int FPM = 4;
  localparam int TO  = 16;

  logic clk = 1'b0, resetn = 1'b0;
  logic frame_tick = 1'b0, enemy_active = 1'b0, self_done = 1'b0, enemy_done = 1'b0;
  logic self_start, enemy_start, datapath_select, erase, plot, update_en, busy, overrun, timeout_err;

  always #10 clk = ~clk;

  draw_scheduler #(.FRAMES_PER_MOVE(FPM), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .enemy_active(enemy_active),
    .self_done(self_done), .enemy_done(enemy_done), .self_start(self_start),
    .enemy_start(enemy_start), .datapath_select(datapath_select), .erase(erase),
    .plot(plot), .update_en(update_en), .busy(busy), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic int outs();
    return int'({self_start, enemy_start, datapath_select, erase, plot,
                 update_en, busy, overrun, timeout_err});
  endfunction

  typedef struct {
    logic       tick, ea, sd, ed;
    logic [8:0] exp;  // {ss, es, sel, erase, plot, upd, busy, ovr, terr}
  } vec_t;
  vec_t tbl[13];

  // monitor / responder state
  int   cyc, ss_cnt, es_cnt, plot_cnt, es_plot, upd_cnt, frame_no, last_plot, fall;
  int   sd_cnt, ed_cnt, dly;
  bit   withhold_self, spur, sel1, prev_busy, upd_ok;
  logic [2:0]  last_start;
  logic [11:0] seq;
  logic [15:0] upd_frames;

  task automatic clr_mon();
    cyc = 0; ss_cnt = 0; es_cnt = 0; plot_cnt = 0; es_plot = 0; upd_cnt = 0; frame_no = 0;
    last_plot = -10; fall = -1; sd_cnt = 0; ed_cnt = 0; withhold_self = 0; spur = 0;
    sel1 = 0; prev_busy = 0; upd_ok = 1; last_start = 3'b000; seq = '0; upd_frames = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    frame_tick = 1'b0; self_done = 1'b0; enemy_done = 1'b0;
    if (sd_cnt > 0) begin sd_cnt--; if (sd_cnt == 0) self_done = 1'b1; end
    if (ed_cnt > 0) begin ed_cnt--; if (ed_cnt == 0) enemy_done = 1'b1; end
    if (self_start) begin
      ss_cnt++;
      if (erase) frame_no++;
      last_start = {1'b0, datapath_select, erase};
      seq = {seq[8:0], last_start};
      if (withhold_self) withhold_self = 0; else sd_cnt = dly;
    end
    if (enemy_start) begin
      es_cnt++;
      last_start = {1'b1, datapath_select, erase};
      seq = {seq[8:0], last_start};
      ed_cnt = dly;
    end
    if (plot) begin plot_cnt++; last_plot = cyc; end
    if (plot && !datapath_select && erase) es_plot++;
    if (datapath_select) sel1 = 1;
    if (update_en) begin
      upd_cnt++;
      upd_frames[frame_no[3:0]] = 1'b1;
      if (last_start != 3'b111) upd_ok = 0;
    end
    if (prev_busy && !busy) fall = cyc;
    prev_busy = busy;
    if (spur && (cyc % 3 == 0)) enemy_done = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 2000 && busy; i++) step();
    chk({nm, "_idle"}, int'(busy), 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    frame_tick = 1'b0; self_done = 1'b0; enemy_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    clr_mon();
  endtask

  task automatic run_frame(input string nm);
    frame_tick = 1'b1;
    step();
    wait_idle(nm);
  endtask

  initial begin
    clr_mon();
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 9'b100100100};  // ES_START
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'b000110100};  // ES_WAIT
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 9'b000110100};  // wrong done ignored
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b011100100};  // EE_START (en_l held)
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'b001110100};  // EE_WAIT
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b001110100};  // wrong done ignored
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 9'b000000100};  // UPDATE, frame 1: no update_en
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9'b100000100};  // DS_START
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b000010100};  // done during START ignored
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b011000100};  // DE_START
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'b001010100};  // DE_WAIT
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 9'b000000010};  // IDLE, tick captured, overrun
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'b100100110};  // pending tick starts frame

    #5;
    chk("reset_outs_async", outs(), 0);
    @(posedge clk); #1;
    chk("reset_outs", outs(), 0);
    resetn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      frame_tick = tbl[i].tick; enemy_active = tbl[i].ea;
      self_done = tbl[i].sd;    enemy_done = tbl[i].ed;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), outs(), int'(tbl[i].exp));
      frame_tick = 1'b0; self_done = 1'b0; enemy_done = 1'b0;
    end

    // full frame with enemy, done 5 cycles after each start
    do_reset();
    dly = 5; enemy_active = 1'b1;
    run_frame("t1");
    chk("t1_start_order", int'(seq), int'(12'b001_111_000_110));
    chk("t1_plot_cycles", plot_cnt, 20);
    chk("t1_busy_fall", fall, last_plot + 1);

    // enemy absent at tick, appears mid-frame, spurious enemy_done
    do_reset();
    dly = 3; enemy_active = 1'b0;
    frame_tick = 1'b1;
    step();
    enemy_active = 1'b1; spur = 1;
    wait_idle("t2");
    chk("t2_self_starts", ss_cnt, 2);
    chk("t2_enemy_starts", es_cnt, 0);
    chk("t2_sel_never_1", int'(sel1), 0);

    // update_en cadence over 8 frames
    do_reset();
    dly = 2; enemy_active = 1'b1;
    for (int f = 0; f < 8; f++) run_frame($sformatf("t3f%0d", f));
    chk("t3_upd_count", upd_cnt, 2);
    chk("t3_upd_frames", int'(upd_frames), 32'h0110);
    chk("t3_upd_after_ee", int'(upd_ok), 1);

    // self_done withheld in ES_WAIT
    do_reset();
    dly = 2; enemy_active = 1'b0; withhold_self = 1;
    run_frame("t4");
    chk("t4_es_wait_len", es_plot, TO);
    chk("t4_timeout_err", int'(timeout_err), 1);
    chk("t4_completed", ss_cnt, 2);

    // three ticks while busy: one extra frame
    do_reset();
    dly = 2; enemy_active = 1'b0;
    frame_tick = 1'b1; step();
    step();
    frame_tick = 1'b1; step();
    step();
    frame_tick = 1'b1; step();
    frame_tick = 1'b1; step();
    repeat (120) step();
    chk("t5_overrun", int'(overrun), 1);
    chk("t5_frames", ss_cnt, 4);
    chk("t5_idle", int'(busy), 0);

    // reset during DS_WAIT
    do_reset();
    dly = 4; enemy_active = 1'b1;
    frame_tick = 1'b1; step();
    step();
    frame_tick = 1'b1; step();
    for (int i = 0; i < 500 && !(plot && !datapath_select && !erase); i++) step();
    chk("t6_reach_ds_wait", int'(plot && !datapath_select && !erase), 1);
    chk("t6_overrun_pre", int'(overrun), 1);
    #3 resetn = 1'b0;
    #1 chk("t6_async_outs", outs(), 0);
    @(posedge clk); #1 resetn = 1'b1;
    clr_mon();
    repeat (10) step();
    chk("t6_no_start", ss_cnt, 0);
    chk("t6_flags_clear", int'({busy, overrun, timeout_err}), 0);
    frame_tick = 1'b1; step();
    chk("t6_restart", int'(self_start), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
